// File: rtl/ring_buffer_pkg.sv
// Shared constants, pointer types and pointer arithmetic helpers for the ring buffer consumer.
// Pointers carry one extra wrap bit above the RAM address so that full and empty can be told apart.
package ring_buffer_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADR_WIDTH_DEF  = 8;
    localparam int PTR_WORD_WIDTH = 32;

    typedef logic [ADR_WIDTH_DEF:0]    ptr_t;
    typedef logic [PTR_WORD_WIDTH-1:0] ptr_word_t;

    // Callers zero-extend narrower pointers to ptr_word_t so one helper serves every ADR_WIDTH.
    function automatic logic ptr_empty(input ptr_word_t a, input ptr_word_t b);
        return a == b;
    endfunction

    function automatic ptr_word_t ptr_count(input ptr_word_t a, input ptr_word_t b,
                                            input int adr_width);
        ptr_word_t mask;
        mask = (ptr_word_t'(1) << (adr_width + 1)) - ptr_word_t'(1);
        return (a - b) & mask;
    endfunction

endpackage

// File: rtl/ring_reader_obuf.sv
// Two-entry output FIFO that absorbs the RAM read latency; the head entry is held in a register.
module ring_reader_obuf
    import ring_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [1:0]            occ
);

    logic [DATA_WIDTH-1:0] second;

    // NOTE: two data registers are cheap enough to reset, which keeps out_data at 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_data <= '0;
            second    <= '0;
            occ       <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments let every branch read the pre-edge occupancy.
            unique case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) head_data <= push_data;
                    else             second    <= push_data;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    head_data <= second;
                    occ       <= occ - 2'd1;
                end
                2'b11: begin
                    // Capture and drain together: occupancy holds, the queue shifts by one.
                    if (occ == 2'd2) begin
                        head_data <= second;
                        second    <= push_data;
                    end else begin
                        head_data <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ring_buffer_reader.sv
// Consumer engine for a RAM-backed ring: issues reads, buffers the 1-cycle RAM latency,
// presents a valid/ready stream and returns the tail pointer to the producer.
module ring_buffer_reader
    import ring_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADR_WIDTH  = ADR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [ADR_WIDTH:0]    head_ptr,
    output logic [ADR_WIDTH:0]    tail_ptr,
    output logic [ADR_WIDTH-1:0]  ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    typedef logic [ADR_WIDTH:0] ring_ptr_t;

    ring_ptr_t  iss_ptr;
    logic       inflight;
    logic [1:0] occ;
    logic [2:0] committed;
    logic       pop;
    logic       issue;

    assign pop       = out_valid & out_ready;
    // Slots that will be taken after this edge: buffered plus in flight, less what drains now.
    assign committed = 3'(occ) + 3'(inflight) - 3'(pop);
    assign issue     = en
                     & ~ptr_empty(ptr_word_t'(iss_ptr), ptr_word_t'(head_ptr))
                     & (committed < 3'd2);

    assign ram_rd_addr = iss_ptr[ADR_WIDTH-1:0];
    assign out_valid   = (occ != 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_ptr  <= '0;
            tail_ptr <= '0;
            inflight <= 1'b0;
        end else begin
            if (issue) iss_ptr <= iss_ptr + ring_ptr_t'(1);
            if (pop)   tail_ptr <= tail_ptr + ring_ptr_t'(1);
            inflight <= issue;
        end
    end

    ring_reader_obuf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_obuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight),
        .push_data (ram_q),
        .pop       (pop),
        .head_data (out_data),
        .occ       (occ)
    );

endmodule
